// File: rtl/bm_tile_pkg.sv
// Shared maze-grid definitions: tile codes, grid geometry and frame limits
// used by the movers and the move-check scheduler.
package bm_tile_pkg;

  typedef enum logic [1:0] {
    TILE_EMPTY  = 2'd0,
    TILE_COLUMN = 2'd1,
    TILE_BRICK  = 2'd2,
    TILE_BOMB   = 2'd3
  } tile_code_t;

  localparam int unsigned GRID_COLS   = 19;
  localparam int unsigned GRID_ROWS   = 13;
  localparam int unsigned TILE_SHIFT  = 5;
  localparam int unsigned SPRITE_SIZE = 32;

  localparam int unsigned COORD_W     = 11;
  localparam int unsigned CALC_W      = 12;
  localparam int unsigned TILE_ADDR_W = 8;
  localparam int unsigned TILE_CODE_W = 2;

  // Frame limits: a sprite's top-left may range over the whole grid minus one tile.
  localparam int unsigned GRID_X0_DEF = 15;
  localparam int unsigned GRID_Y0_DEF = 48;
  localparam int unsigned MAX_X_OFS   = (GRID_COLS - 1) * SPRITE_SIZE;
  localparam int unsigned MAX_Y_OFS   = (GRID_ROWS - 1) * SPRITE_SIZE;
  localparam int unsigned CORNER_OFS  = SPRITE_SIZE - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_WAIT,
    S_EVAL,
    S_DONE
  } sched_state_t;

  // Everything except an empty tile stops a mover.
  function automatic logic is_blocking(input logic [TILE_CODE_W-1:0] code);
    return tile_code_t'(code) != TILE_EMPTY;
  endfunction

endpackage

// File: rtl/tile_addr_calc.sv
// Maps a sprite top-left position and corner index to the tile under that
// corner, and flags positions that lie outside the playable frame.
module tile_addr_calc
  import bm_tile_pkg::*;
#(
  parameter int unsigned GRID_X0 = GRID_X0_DEF,
  parameter int unsigned GRID_Y0 = GRID_Y0_DEF
) (
  input  logic signed [COORD_W-1:0]     x_i,
  input  logic signed [COORD_W-1:0]     y_i,
  input  logic        [1:0]             corner_i,
  output logic                          out_of_frame_o,
  output logic        [TILE_ADDR_W-1:0] tile_addr_o
);

  localparam logic signed [CALC_W-1:0] X0         = CALC_W'(GRID_X0);
  localparam logic signed [CALC_W-1:0] Y0         = CALC_W'(GRID_Y0);
  localparam logic signed [CALC_W-1:0] MAX_DX     = CALC_W'(MAX_X_OFS);
  localparam logic signed [CALC_W-1:0] MAX_DY     = CALC_W'(MAX_Y_OFS);
  localparam logic signed [CALC_W-1:0] OFS        = CALC_W'(CORNER_OFS);
  localparam logic signed [CALC_W-1:0] ROW_STRIDE = CALC_W'(GRID_COLS);

  logic signed [CALC_W-1:0] dx, dy, cx, cy, col, row;

  // Corner bit 0 selects the right edge, bit 1 the bottom edge.
  always_comb begin
    dx = CALC_W'(x_i) - X0;
    dy = CALC_W'(y_i) - Y0;
    out_of_frame_o = dx[CALC_W-1] || (dx > MAX_DX) || dy[CALC_W-1] || (dy > MAX_DY);
    cx  = dx + (corner_i[0] ? OFS : '0);
    cy  = dy + (corner_i[1] ? OFS : '0);
    col = cx >>> TILE_SHIFT;
    row = cy >>> TILE_SHIFT;
    tile_addr_o = TILE_ADDR_W'(row * ROW_STRIDE + col);
  end

endmodule

// File: rtl/move_check_scheduler.sv
// Per-frame sweep that checks every mover's candidate position against the
// tile map through the shared single-port read interface.
module move_check_scheduler
  import bm_tile_pkg::*;
#(
  parameter int unsigned N_MOVERS     = 4,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned GRID_X0      = GRID_X0_DEF,
  parameter int unsigned GRID_Y0      = GRID_Y0_DEF
) (
  input  logic                          clk,
  input  logic                          resetN,
  input  logic                          startOfFrame,
  input  logic [N_MOVERS-1:0]           cand_req,
  input  logic [N_MOVERS*COORD_W-1:0]   cand_x,
  input  logic [N_MOVERS*COORD_W-1:0]   cand_y,
  input  logic                          map_busy,
  output logic                          tile_rd,
  output logic [TILE_ADDR_W-1:0]        tile_addr,
  input  logic [TILE_CODE_W-1:0]        tile_data,
  output logic [N_MOVERS-1:0]           valid_pos,
  output logic                          check_done,
  output logic                          busy
);

  localparam int unsigned IDX_W = $clog2(N_MOVERS + 1);
  localparam int unsigned SEL_W = (N_MOVERS > 1) ? $clog2(N_MOVERS) : 1;
  localparam int unsigned CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned XY_W  = N_MOVERS * COORD_W;

  sched_state_t                 state_q;
  logic [IDX_W-1:0]             idx_q;
  logic [IDX_W-1:0]             idx_d;
  logic [SEL_W-1:0]             sel;
  logic [1:0]                   k_q;
  logic [CNT_W-1:0]             wait_cnt_q;
  logic [N_MOVERS-1:0]          req_q;
  logic [XY_W-1:0]              x_q;
  logic [XY_W-1:0]              y_q;
  logic [N_MOVERS-1:0]          valid_q;
  logic                         tile_rd_q;
  logic [TILE_ADDR_W-1:0]       tile_addr_q;
  logic                         done_q;
  logic                         busy_q;

  logic signed [COORD_W-1:0]    cur_x;
  logic signed [COORD_W-1:0]    cur_y;
  logic                         cur_oof;
  logic [TILE_ADDR_W-1:0]       cur_addr;

  assign idx_d = idx_q + IDX_W'(1);
  assign sel   = idx_q[SEL_W-1:0];
  assign cur_x = x_q[32'(sel) * COORD_W +: COORD_W];
  assign cur_y = y_q[32'(sel) * COORD_W +: COORD_W];

  tile_addr_calc #(
    .GRID_X0 (GRID_X0),
    .GRID_Y0 (GRID_Y0)
  ) u_addr_calc (
    .x_i            (cur_x),
    .y_i            (cur_y),
    .corner_i       (k_q),
    .out_of_frame_o (cur_oof),
    .tile_addr_o    (cur_addr)
  );

  // Sweep FSM; a new frame pulse always restarts from mover 0, even mid-sweep.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      k_q         <= '0;
      wait_cnt_q  <= '0;
      req_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      valid_q     <= '0;
      tile_rd_q   <= 1'b0;
      tile_addr_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      tile_rd_q <= 1'b0;
      done_q    <= 1'b0;
      if (startOfFrame) begin
        req_q   <= cand_req;
        x_q     <= cand_x;
        y_q     <= cand_y;
        idx_q   <= '0;
        k_q     <= '0;
        busy_q  <= 1'b1;
        state_q <= S_SELECT;
      end else begin
        unique case (state_q)
          S_IDLE: ;
          S_SELECT: begin
            if (idx_q == IDX_W'(N_MOVERS)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (!req_q[sel]) begin
              idx_q <= idx_d;
            end else if (cur_oof) begin
              valid_q[sel] <= 1'b0;
              idx_q        <= idx_d;
            end else begin
              k_q     <= '0;
              state_q <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (!map_busy) begin
              tile_rd_q   <= 1'b1;
              tile_addr_q <= cur_addr;
              wait_cnt_q  <= '0;
              state_q     <= S_WAIT;
            end
          end
          // The read is committed once issued; map_busy is ignored here.
          S_WAIT: begin
            if (wait_cnt_q == CNT_W'(READ_LATENCY - 1)) begin
              state_q <= S_EVAL;
            end else begin
              wait_cnt_q <= wait_cnt_q + CNT_W'(1);
            end
          end
          S_EVAL: begin
            if (is_blocking(tile_data)) begin
              valid_q[sel] <= 1'b0;
              idx_q        <= idx_d;
              state_q      <= S_SELECT;
            end else if (k_q == 2'd3) begin
              valid_q[sel] <= 1'b1;
              idx_q        <= idx_d;
              state_q      <= S_SELECT;
            end else begin
              k_q     <= k_q + 2'd1;
              state_q <= S_ISSUE;
            end
          end
          S_DONE: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign tile_rd    = tile_rd_q;
  assign tile_addr  = tile_addr_q;
  assign valid_pos  = valid_q;
  assign check_done = done_q;
  assign busy       = busy_q;

endmodule
